// File: rtl/intr_arbiter.sv
// Fixed-priority interrupt arbiter: edge-captured pending bits, software enable,
// and a single-in-service claim/complete handshake over a 4-word register port.
module intr_arbiter #(
  parameter int N_SRC = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_SRC-1:0] i_src_irq,
  input  logic             i_reg_en,
  input  logic             i_reg_we,
  input  logic [3:0]       i_reg_addr,
  input  logic [31:0]      i_reg_wdata,
  output logic [31:0]      o_reg_rdata,
  output logic             o_irq_out
);

  localparam logic [3:0] ADDR_ENABLE  = 4'h0;
  localparam logic [3:0] ADDR_PENDING = 4'h4;
  localparam logic [3:0] ADDR_CLAIM   = 4'h8;
  localparam logic [3:0] ADDR_STATUS  = 4'hC;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_SERVICE = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N_SRC-1:0]   r_pending;
  logic [N_SRC-1:0]   r_enable;
  logic [N_SRC-1:0]   r_src_prev;
  logic [4:0]         r_svc_id;
  logic [31:0]        r_rdata;
  logic               r_irq;

  logic               w_rd;
  logic               w_wr;
  logic [N_SRC-1:0]   w_active;
  logic [4:0]         w_cand_id;
  logic               w_claim;
  logic               w_complete;
  logic [N_SRC-1:0]   w_clr;
  logic [N_SRC-1:0]   w_rise;
  logic [N_SRC-1:0]   w_pending_nxt;
  logic [N_SRC-1:0]   w_enable_nxt;
  logic [4:0]         w_svc_id_nxt;
  logic [31:0]        w_rdata_nxt;
  logic               w_irq_nxt;
  logic               w_unused;

  assign w_rd       = i_reg_en & ~i_reg_we;
  assign w_wr       = i_reg_en & i_reg_we;
  assign w_active   = r_pending & r_enable;
  assign w_claim    = w_rd & (i_reg_addr == ADDR_CLAIM) & (r_state == S_IDLE) & (w_cand_id != 5'd0);
  assign w_complete = w_wr & (i_reg_addr == ADDR_CLAIM) & (r_state == S_SERVICE) &
                      (i_reg_wdata[4:0] == r_svc_id);
  assign w_rise     = i_src_irq & ~r_src_prev;
  assign w_unused   = ^i_reg_wdata[31:N_SRC];

  // Lowest active index wins: scan downward so the smallest index is written last.
  always_comb begin
    w_cand_id = 5'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      w_cand_id = w_active[i] ? 5'(i + 1) : w_cand_id;
    end
  end

  // A rising edge in the claim cycle beats the claim's clear.
  always_comb begin
    w_clr         = w_claim ? (N_SRC'(1) << (w_cand_id - 5'd1)) : '0;
    w_pending_nxt = (r_pending & ~w_clr) | w_rise;
    w_enable_nxt  = (w_wr && (i_reg_addr == ADDR_ENABLE)) ? i_reg_wdata[N_SRC-1:0] : r_enable;
    if (w_claim) begin
      w_svc_id_nxt = w_cand_id;
    end else if (w_complete) begin
      w_svc_id_nxt = 5'd0;
    end else begin
      w_svc_id_nxt = r_svc_id;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    w_state_nxt = w_claim ? S_SERVICE : S_IDLE;
      S_SERVICE: w_state_nxt = w_complete ? S_IDLE : S_SERVICE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Output next values; irq is gated by the post-access state so a claim drops it at once.
  always_comb begin
    w_rdata_nxt = r_rdata;
    if (w_rd) begin
      case (i_reg_addr)
        ADDR_ENABLE:  w_rdata_nxt = 32'(r_enable);
        ADDR_PENDING: w_rdata_nxt = 32'(r_pending);
        ADDR_CLAIM:   w_rdata_nxt = (r_state == S_IDLE) ? 32'(w_cand_id) : 32'd0;
        ADDR_STATUS:  w_rdata_nxt = {26'd0, (r_state == S_SERVICE), r_svc_id};
        default:      w_rdata_nxt = 32'd0;
      endcase
    end else begin
      w_rdata_nxt = r_rdata;
    end
    w_irq_nxt = (w_state_nxt == S_IDLE) & (|(r_pending & w_enable_nxt));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_pending  <= '0;
      r_enable   <= '0;
      r_src_prev <= '0;
      r_svc_id   <= 5'd0;
      r_rdata    <= 32'd0;
      r_irq      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_enable   <= w_enable_nxt;
      r_src_prev <= i_src_irq;
      r_svc_id   <= w_svc_id_nxt;
      r_rdata    <= w_rdata_nxt;
      r_irq      <= w_irq_nxt;
    end
  end

  assign o_reg_rdata = r_rdata;
  assign o_irq_out   = r_irq;

endmodule

// File: tb/tb_intr_arbiter.sv
// Directed self-checking bench for intr_arbiter.
module tb_intr_arbiter;

  localparam logic [3:0] A_EN  = 4'h0;
  localparam logic [3:0] A_PND = 4'h4;
  localparam logic [3:0] A_CLM = 4'h8;
  localparam logic [3:0] A_ST  = 4'hC;

  logic        clk;
  logic        rst;
  logic [7:0]  src_irq;
  logic        reg_en;
  logic        reg_we;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        irq_out;

  int errors = 0;
  int checks = 0;

  intr_arbiter #(.N_SRC(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_src_irq   (src_irq),
    .i_reg_en    (reg_en),
    .i_reg_we    (reg_we),
    .i_reg_addr  (reg_addr),
    .i_reg_wdata (reg_wdata),
    .o_reg_rdata (reg_rdata),
    .o_irq_out   (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] addr, output logic [31:0] data);
    @(negedge clk);
    reg_en = 1'b1; reg_we = 1'b0; reg_addr = addr;
    @(negedge clk);
    reg_en = 1'b0;
    data = reg_rdata;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    reg_en = 1'b1; reg_we = 1'b1; reg_addr = addr; reg_wdata = data;
    @(negedge clk);
    reg_en = 1'b0; reg_we = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] mask);
    @(negedge clk);
    src_irq = mask;
    @(negedge clk);
    src_irq = 8'h00;
  endtask

  logic [31:0] d;

  initial begin
    rst = 1'b1; src_irq = 8'h00; reg_en = 1'b0; reg_we = 1'b0;
    reg_addr = 4'h0; reg_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("irq_in_reset", {31'd0, irq_out}, 32'd0);
    chk("rdata_in_reset", reg_rdata, 32'd0);
    rst = 1'b0;

    rd(A_EN, d);  chk("reset_enable", d, 32'h0);
    rd(A_PND, d); chk("reset_pending", d, 32'h0);
    rd(A_CLM, d); chk("reset_claim", d, 32'h0);
    rd(A_ST, d);  chk("reset_status", d, 32'h0);
    chk("reset_irq", {31'd0, irq_out}, 32'd0);

    wr(A_EN, 32'hFFFF_FFFF);
    rd(A_EN, d);  chk("enable_upper_zero", d, 32'h0000_00FF);
    rd(4'h2, d);  chk("unmapped_read", d, 32'h0);

    // Two sources in one cycle, lowest index claimed first
    wr(A_EN, 32'h0A);
    pulse(8'h0A);
    chk("irq_k1_low", {31'd0, irq_out}, 32'd0);
    @(negedge clk);
    chk("irq_k2_high", {31'd0, irq_out}, 32'd1);
    rd(A_PND, d); chk("pending_0a", d, 32'h0A);
    rd(A_CLM, d); chk("claim_2", d, 32'd2);
    chk("irq_low_after_claim", {31'd0, irq_out}, 32'd0);
    rd(A_ST, d);  chk("status_svc2", d, 32'h22);
    rd(A_CLM, d); chk("claim_in_service", d, 32'd0);
    wr(A_CLM, 32'd4);
    rd(A_ST, d);  chk("status_bad_complete", d, 32'h22);
    chk("irq_low_in_service", {31'd0, irq_out}, 32'd0);
    wr(A_CLM, 32'd2);
    chk("irq_after_complete", {31'd0, irq_out}, 32'd1);
    rd(A_CLM, d); chk("claim_4", d, 32'd4);
    rd(A_PND, d); chk("pending_empty", d, 32'h0);
    wr(A_CLM, 32'd4);
    chk("irq_idle_nothing", {31'd0, irq_out}, 32'd0);
    wr(A_CLM, 32'd4);
    rd(A_ST, d);  chk("complete_in_idle", d, 32'h0);

    // Disabled source still latches; enabling raises irq
    wr(A_EN, 32'h0);
    pulse(8'h01);
    rd(A_PND, d); chk("pending_disabled", d, 32'h01);
    chk("irq_disabled", {31'd0, irq_out}, 32'd0);
    rd(A_CLM, d); chk("claim_disabled", d, 32'd0);
    wr(A_EN, 32'h01);
    chk("irq_after_enable", {31'd0, irq_out}, 32'd1);
    rd(A_CLM, d); chk("claim_1", d, 32'd1);
    wr(A_CLM, 32'd1);

    // Re-pend of the in-service source
    wr(A_EN, 32'h04);
    pulse(8'h04);
    rd(A_CLM, d); chk("claim_3", d, 32'd3);
    pulse(8'h04);
    rd(A_PND, d); chk("repend_3", d, 32'h04);
    chk("irq_repend_service", {31'd0, irq_out}, 32'd0);
    wr(A_CLM, 32'd3);
    chk("irq_after_complete3", {31'd0, irq_out}, 32'd1);
    rd(A_CLM, d); chk("claim_3_again", d, 32'd3);
    wr(A_CLM, 32'd3);

    // Edge in the same cycle as the claim of that source: set wins
    wr(A_EN, 32'h20);
    pulse(8'h20);
    @(negedge clk);
    reg_en = 1'b1; reg_we = 1'b0; reg_addr = A_CLM; src_irq = 8'h20;
    @(negedge clk);
    reg_en = 1'b0;
    chk("claim_6", reg_rdata, 32'd6);
    rd(A_PND, d); chk("set_wins", d, 32'h20);
    rd(A_ST, d);  chk("status_svc6", d, 32'h26);
    chk("irq_svc6", {31'd0, irq_out}, 32'd0);

    // Reset mid-service
    @(negedge clk);
    rst = 1'b1; src_irq = 8'h00;
    @(negedge clk);
    chk("irq_mid_reset", {31'd0, irq_out}, 32'd0);
    rst = 1'b0;
    rd(A_ST, d);  chk("status_after_rst", d, 32'h0);
    rd(A_PND, d); chk("pending_after_rst", d, 32'h0);
    chk("irq_after_rst", {31'd0, irq_out}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
